// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port architectural register file with a pending-producer
// scoreboard and a sticky out-of-range index flag.
//   clk, rst_n        : clock, synchronous active-low reset
//   srcA/srcB         : read indices      -> valA/valB data, rdyA/rdyB ready
//   dstE/valE         : write port E
//   dstM/valM         : write port M (wins over E on the same index)
//   claim_idx         : mark a register pending (RNONE = no claim)
//   err_idx           : sticky, set when any index lies in [NREGS, RNONE)
// Index value all-ones (RNONE) means "no access" on every index port.

// One architectural register plus its pending bit.
module reg_file_cell #(
  parameter int                 DATA_W  = 64,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_e,
  input  logic              we_m,
  input  logic              claim,
  input  logic [DATA_W-1:0] din_e,
  input  logic [DATA_W-1:0] din_m,
  output logic [DATA_W-1:0] q,
  output logic              pend
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= RST_VAL;
      pend <= 1'b0;
    end else begin
      if (we_m)      q <= din_m;
      else if (we_e) q <= din_e;
      // a claim in the same cycle as a write keeps the register pending
      if (claim)             pend <= 1'b1;
      else if (we_m || we_e) pend <= 1'b0;
    end
  end
endmodule

// One combinational read port with optional forwarding from the write ports.
module reg_file_rd #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int IDX_W  = 4,
  parameter int BYPASS = 1
) (
  input  logic [IDX_W-1:0]             src,
  input  logic                         src_ok,
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [NREGS-1:0]             pend,
  input  logic                         e_vld,
  input  logic [IDX_W-1:0]             dstE,
  input  logic [DATA_W-1:0]            valE,
  input  logic                         m_vld,
  input  logic [IDX_W-1:0]             dstM,
  input  logic [DATA_W-1:0]            valM,
  input  logic                         c_vld,
  input  logic [IDX_W-1:0]             claim_idx,
  output logic [DATA_W-1:0]            val,
  output logic                         rdy
);
  logic reclaim;
  assign reclaim = c_vld && (claim_idx == src);

  always_comb begin
    val = '0;
    rdy = 1'b1;
    if (src_ok) begin
      for (int r = 0; r < NREGS; r++) begin
        if (src == IDX_W'(r)) begin
          val = regs[r];
          rdy = ~pend[r];
        end
      end
      if (BYPASS != 0) begin
        // M forwarding wins over E, mirroring the write priority
        if (m_vld && dstM == src) begin
          val = valM;
          rdy = ~reclaim;
        end else if (e_vld && dstE == src) begin
          val = valE;
          rdy = ~reclaim;
        end
      end
    end
  end
endmodule

module reg_file_mp #(
  parameter int                DATA_W  = 64,
  parameter int                NREGS   = 15,
  parameter int                IDX_W   = 4,
  parameter int                BYPASS  = 1,
  parameter logic [DATA_W-1:0] RSP_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  srcA,
  input  logic [IDX_W-1:0]  srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              rdyA,
  output logic              rdyB,
  input  logic [IDX_W-1:0]  dstE,
  input  logic [IDX_W-1:0]  dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [IDX_W-1:0]  claim_idx,
  output logic              err_idx
);
  localparam logic [IDX_W-1:0] RNONE = '1;

  function automatic logic idx_ok(input logic [IDX_W-1:0] i);
    return (i != RNONE) && (int'(i) < NREGS);
  endfunction

  function automatic logic idx_bad(input logic [IDX_W-1:0] i);
    return (i != RNONE) && !(int'(i) < NREGS);
  endfunction

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             pend;
  logic                         e_vld, m_vld, c_vld;

  assign e_vld = idx_ok(dstE);
  assign m_vld = idx_ok(dstM);
  assign c_vld = idx_ok(claim_idx);

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    reg_file_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL ((i == 4) ? RSP_RST : '0)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we_e  (e_vld && dstE == IDX_W'(i)),
      .we_m  (m_vld && dstM == IDX_W'(i)),
      .claim (c_vld && claim_idx == IDX_W'(i)),
      .din_e (valE),
      .din_m (valM),
      .q     (regs[i]),
      .pend  (pend[i])
    );
  end

  logic [1:0][IDX_W-1:0]  src;
  logic [1:0][DATA_W-1:0] val;
  logic [1:0]             rdy;

  assign src  = {srcB, srcA};
  assign valA = val[0];
  assign valB = val[1];
  assign rdyA = rdy[0];
  assign rdyB = rdy[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    reg_file_rd #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .IDX_W  (IDX_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .src       (src[p]),
      .src_ok    (idx_ok(src[p])),
      .regs      (regs),
      .pend      (pend),
      .e_vld     (e_vld),
      .dstE      (dstE),
      .valE      (valE),
      .m_vld     (m_vld),
      .dstM      (dstM),
      .valM      (valM),
      .c_vld     (c_vld),
      .claim_idx (claim_idx),
      .val       (val[p]),
      .rdy       (rdy[p])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_idx <= 1'b0;
    else if (idx_bad(srcA) || idx_bad(srcB) || idx_bad(dstE) ||
             idx_bad(dstM) || idx_bad(claim_idx))
      err_idx <= 1'b1;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: u1 = forwarding on, 13 registers; u0 = forwarding off,
// 15 registers. Both share the same stimulus.
module tb_reg_file_mp;
  localparam logic [63:0] RSP1 = 64'hDEAD_BEEF_0000_0004;
  localparam logic [63:0] RSP0 = 64'h0000_0000_0000_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  srcA, srcB, dstE, dstM, claim_idx;
  logic [63:0] valE, valM;
  logic [63:0] valA1, valB1, valA0, valB0;
  logic        rdyA1, rdyB1, rdyA0, rdyB0, err1, err0;
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp1 [0:12];

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(64), .NREGS(13), .IDX_W(4), .BYPASS(1), .RSP_RST(RSP1)) u1 (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1),
    .rdyA(rdyA1), .rdyB(rdyB1), .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .claim_idx(claim_idx), .err_idx(err1));

  reg_file_mp #(.DATA_W(64), .NREGS(15), .IDX_W(4), .BYPASS(0), .RSP_RST(RSP0)) u0 (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0),
    .rdyA(rdyA0), .rdyB(rdyB0), .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .claim_idx(claim_idx), .err_idx(err0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    srcA = 4'hF; srcB = 4'hF; dstE = 4'hF; dstM = 4'hF; claim_idx = 4'hF;
    valE = '0; valM = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_err1", {63'd0, err1}, 64'd0);
    chk("rst_err0", {63'd0, err0}, 64'd0);

    // reset contents, all indices including RNONE and out-of-range
    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i);
      #1;
      chk($sformatf("rst_val1_%0d", i), valA1, (i == 4) ? RSP1 : 64'd0);
      chk($sformatf("rst_rdy1_%0d", i), {63'd0, rdyA1}, 64'd1);
      chk($sformatf("rst_val0_%0d", i), valA0, (i == 4) ? RSP0 : 64'd0);
      chk($sformatf("rst_rdy0_%0d", i), {63'd0, rdyA0}, 64'd1);
    end
    srcA = 4'hF;
    tick();

    // E and M to the same register: M wins, also through forwarding
    dstE = 4'd2; valE = 64'h11; dstM = 4'd2; valM = 64'h22; srcA = 4'd2;
    #1;
    chk("same_dst_byp1", valA1, 64'h22);
    chk("same_dst_old0", valA0, 64'h0);
    tick();
    idle(); srcA = 4'd2;
    #1;
    chk("same_dst_q1", valA1, 64'h22);
    chk("same_dst_q0", valA0, 64'h22);

    // no-forwarding read sees the old value until after the edge
    dstE = 4'd3; valE = 64'h5; srcB = 4'd3;
    #1;
    chk("nobyp_old0", valB0, 64'h0);
    chk("byp_new1", valB1, 64'h5);
    tick();
    idle(); srcB = 4'd3;
    #1;
    chk("nobyp_new0", valB0, 64'h5);

    // scoreboard on register 7
    idle(); claim_idx = 4'd7; srcA = 4'd7;
    #1;
    chk("claim_pre_rdy1", {63'd0, rdyA1}, 64'd1);
    tick();
    claim_idx = 4'hF;
    #1;
    chk("claim_rdy1", {63'd0, rdyA1}, 64'd0);
    chk("claim_rdy0", {63'd0, rdyA0}, 64'd0);
    dstM = 4'd7; valM = 64'h77; claim_idx = 4'd7;
    #1;
    chk("reclaim_byp_rdy1", {63'd0, rdyA1}, 64'd0);
    chk("reclaim_byp_val1", valA1, 64'h77);
    tick();
    idle(); srcA = 4'd7;
    #1;
    chk("reclaim_rdy1", {63'd0, rdyA1}, 64'd0);
    chk("reclaim_rdy0", {63'd0, rdyA0}, 64'd0);
    dstM = 4'd7; valM = 64'h78;
    #1;
    chk("wr_byp_rdy1", {63'd0, rdyA1}, 64'd1);
    chk("wr_nobyp_rdy0", {63'd0, rdyA0}, 64'd0);
    tick();
    idle(); srcA = 4'd7; srcB = 4'd7;
    #1;
    chk("clr_rdy1", {63'd0, rdyA1}, 64'd1);
    chk("clr_rdy0", {63'd0, rdyA0}, 64'd1);
    chk("clr_val0", valA0, 64'h78);
    chk("same_src_val1", valB1, valA1 === 64'h78 ? 64'h78 : 64'hx);
    chk("same_src_rdy0", {63'd0, rdyB0}, 64'd1);

    // independent E and M forwarding to different registers
    idle(); dstE = 4'd8; valE = 64'h88; dstM = 4'd9; valM = 64'h99;
    srcA = 4'd8; srcB = 4'd9;
    #1;
    chk("byp_e1", valA1, 64'h88);
    chk("byp_m1", valB1, 64'h99);
    tick();
    idle();

    // index 0xD: out of range on u1, a real register on u0
    dstE = 4'hD; valE = 64'hBAD; srcA = 4'hD;
    #1;
    chk("oor_val1", valA1, 64'h0);
    chk("oor_rdy1", {63'd0, rdyA1}, 64'd1);
    chk("oor_err_pre1", {63'd0, err1}, 64'd0);
    tick();
    idle(); srcA = 4'hD;
    #1;
    chk("oor_err1", {63'd0, err1}, 64'd1);
    chk("oor_err0", {63'd0, err0}, 64'd0);
    chk("inr_val0", valA0, 64'hBAD);
    for (int r = 0; r < 13; r++) exp1[r] = 64'd0;
    exp1[2] = 64'h22; exp1[3] = 64'h5; exp1[4] = RSP1;
    exp1[7] = 64'h78; exp1[8] = 64'h88; exp1[9] = 64'h99;
    for (int r = 0; r < 13; r++) begin
      srcA = 4'(r);
      #1;
      chk($sformatf("oor_keep1_%0d", r), valA1, exp1[r]);
    end
    idle();
    tick(); tick();
    chk("err_sticky1", {63'd0, err1}, 64'd1);

    // claim + write reg 4 together: data lands, stays pending
    dstE = 4'd4; valE = 64'hFF; claim_idx = 4'd4;
    tick();
    idle(); srcA = 4'd4;
    #1;
    chk("r4_val1", valA1, 64'hFF);
    chk("r4_rdy1", {63'd0, rdyA1}, 64'd0);
    chk("r4_rdy0", {63'd0, rdyA0}, 64'd0);

    // mid-operation reset with a write and a claim that must be discarded
    rst_n = 1'b0; dstM = 4'd4; valM = 64'h123; claim_idx = 4'd5;
    #1;
    chk("rst_pre_val0", valA0, 64'hFF);
    tick();
    rst_n = 1'b1; idle(); srcA = 4'd4; srcB = 4'd5;
    #1;
    chk("rst_r4_val1", valA1, RSP1);
    chk("rst_r4_val0", valA0, RSP0);
    chk("rst_r4_rdy1", {63'd0, rdyA1}, 64'd1);
    chk("rst_r4_rdy0", {63'd0, rdyA0}, 64'd1);
    chk("rst_r5_rdy1", {63'd0, rdyB1}, 64'd1);
    chk("rst_err_clr1", {63'd0, err1}, 64'd0);
    srcA = 4'd2;
    #1;
    chk("rst_r2_val1", valA1, 64'h0);
    chk("rst_r2_val0", valA0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 64: register width in bits.
REQ-002 Parameter NREGS, default 15: number of architectural registers, indices 0..NREGS-1.
REQ-003 Parameter IDX_W, default 4: index width; index value 2^IDX_W-1 (0xF) is RNONE, meaning no access.
REQ-004 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-005 Parameter RSP_RST, default 0: reset value of register 4 (%rsp).
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 srcA, srcB  in  IDX_W each  read indices.
REQ-009 valA, valB  out  DATA_W each  read data.
REQ-010 rdyA, rdyB  out  1 each  1 = the source register has no pending producer.
REQ-011 dstE, dstM  in  IDX_W each  write indices.
REQ-012 valE, valM  in  DATA_W each  write data.
REQ-013 claim_idx  in  IDX_W  register to mark pending; RNONE = no claim.
REQ-014 err_idx  out  1  sticky flag for an out-of-range index.

Function
REQ-015 Reads are combinational; valX = reg[srcX].
REQ-016 When srcX = RNONE or srcX >= NREGS: valX = 0 and rdyX = 1.
REQ-017 Writes occur at the rising edge of clk when rst_n = 1 and dstX < NREGS; dstX = RNONE means no write.
REQ-018 When dstE = dstM (both valid), valM is written and valE is discarded.
REQ-019 With BYPASS = 1, a read whose srcX matches a valid dstM or dstE in the same cycle returns the write data combinationally.
REQ-020 In that bypass case, dstM takes priority over dstE.
REQ-021 With BYPASS = 0, reads return the pre-edge contents; new data is visible the cycle after the write.
REQ-022 Scoreboard: one pending bit per register.
REQ-023 A valid claim_idx sets pend[claim_idx] at the clock edge.
REQ-024 A valid write to dstE or dstM clears pend[dst] at the clock edge.
REQ-025 When a claim and a write target the same register in the same cycle, the claim wins and pend stays 1.
REQ-026 rdyX = ~pend[srcX].
REQ-027 With BYPASS = 1, rdyX is also 1 when the same cycle writes srcX and does not re-claim it.
REQ-028 Claiming an already-pending register leaves pend = 1; no counting of outstanding producers.
REQ-029 err_idx sets at the clock edge when any of srcA, srcB, dstE, dstM or claim_idx lies in the range [NREGS, RNONE).
REQ-030 err_idx is cleared only by reset.
REQ-031 Out-of-range writes and claims are ignored and modify no register.
REQ-032 Read ports are independent; srcA = srcB returns identical data and ready values.

Reset
REQ-033 At a clock edge with rst_n = 0, every register is loaded with 0, except register 4, which loads RSP_RST.
REQ-034 At the same reset edge, all pend bits clear and err_idx clears.
REQ-035 Writes and claims presented during a reset cycle are discarded; reset has priority.
REQ-036 Reset asserted mid-operation behaves identically to power-on reset; no partial state survives.
REQ-037 During reset, reads stay combinational and show the current contents until the reset edge, then the reset values.

Verification
REQ-038 Reset then read all indices: valA = 0 for every index except 4, which returns RSP_RST; rdyA = 1 everywhere; err_idx = 0.
REQ-039 Write dstE = 2, valE = 0x11 together with dstM = 2, valM = 0x22: reg[2] = 0x22.
 - With BYPASS = 1, srcA = 2 in the same cycle reads 0x22.
REQ-040 With BYPASS = 0, write dstE = 3, valE = 0x5 and read srcB = 3 in the same cycle:
 - valB shows the old value that cycle;
 - valB = 0x5 on the next cycle.
REQ-041 Claim 7: rdyA = 0 for srcA = 7 the next cycle.
 - In the same cycle, dstM = 7 and claim_idx = 7 together leave rdyA = 0.
 - A following dstM = 7 write without a claim gives rdyA = 1 after the edge.
REQ-042 Index 0xD with NREGS = 13:
 - dstE = 0xD does not change any register; err_idx = 1 the cycle after;
 - err_idx holds until rst_n = 0 and then returns to 0.
REQ-043 Claim 4 and write reg[4] = 0xFF, then assert rst_n = 0 for one edge: reg[4] = RSP_RST, pend[4] = 0.
